// File: rtl/mskaes_128bits_round_ctrl.sv
// Iterative control and state-holding stage for a masked AES-128 core built around an external
// round datapath (round with cleaning). The block accepts a shared plaintext and key, holds the
// state and key share registers, and feeds them to the round for ten rounds while sequencing
// the round constant and the cleaning control. A final cleaned pass yields the last
// AddRoundKey, and the shared ciphertext is returned over a valid/ready handshake.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      plaintext/key handshake
//   sh_plaintext, sh_key     shared inputs, sampled only at the accepting edge
//   out_valid / out_ready    ciphertext handshake
//   sh_ciphertext            registered shared ciphertext
//   sh_state_to_round        state register, drives round sh_state_in
//   sh_key_to_round          key register, drives round sh_key_in
//   sh_RCON                  shared round constant (share 0 carries it)
//   cleaning_on              round cleaning control
//   sh_*_from_round          round outputs (post-MC, next key, post-SR, post-AK)
// Shared buses are bit-major: bit i of share j sits at index i*d+j.
//
// Build option: define MSKAES_REG_CLEAR_EN to wipe the state, key and ciphertext registers at
// the output handshake so no residual shares are kept.

module mskaes_128bits_round_ctrl #(
  parameter int unsigned d       = 2,
  parameter int unsigned LATENCY = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [128*d-1:0] sh_plaintext,
  input  logic [128*d-1:0] sh_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [128*d-1:0] sh_ciphertext,
  output logic [128*d-1:0] sh_state_to_round,
  output logic [128*d-1:0] sh_key_to_round,
  output logic [8*d-1:0]   sh_RCON,
  output logic             cleaning_on,
  input  logic [128*d-1:0] sh_state_from_round,
  input  logic [128*d-1:0] sh_key_from_round,
  input  logic [128*d-1:0] sh_state_SR_from_round,
  input  logic [128*d-1:0] sh_state_AK_from_round
);

  localparam int unsigned W    = 128 * d;
  localparam int unsigned CycW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CycW-1:0] CycLast = CycW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} state_e;

  state_e          fsm_q, fsm_d;
  logic [W-1:0]    state_q, state_d;
  logic [W-1:0]    key_q, key_d;
  logic [W-1:0]    ct_q, ct_d;
  logic [3:0]      rnd_cnt_q, rnd_cnt_d;
  logic [CycW-1:0] cyc_cnt_q, cyc_cnt_d;
  logic            round_end;
  logic            last_round;
  logic [7:0]      rcon;

  assign round_end  = (fsm_q == StRound) && (cyc_cnt_q == CycLast);
  assign last_round = (rnd_cnt_q == 4'd10);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= StIdle;
      state_q   <= '0;
      key_q     <= '0;
      ct_q      <= '0;
      rnd_cnt_q <= '0;
      cyc_cnt_q <= '0;
    end else begin
      fsm_q     <= fsm_d;
      state_q   <= state_d;
      key_q     <= key_d;
      ct_q      <= ct_d;
      rnd_cnt_q <= rnd_cnt_d;
      cyc_cnt_q <= cyc_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      StIdle:  if (in_valid && in_ready) fsm_d = StRound;
      StRound: if (round_end && last_round) fsm_d = StFinal;
      StFinal: fsm_d = StDone;
      StDone:  if (out_ready) fsm_d = StIdle;
      default: fsm_d = StIdle;
    endcase
  end

  // Datapath registers and counters
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    ct_d      = ct_q;
    rnd_cnt_d = rnd_cnt_q;
    cyc_cnt_d = cyc_cnt_q;
    unique case (fsm_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          state_d   = sh_plaintext;
          key_d     = sh_key;
          rnd_cnt_d = 4'd1;
          cyc_cnt_d = '0;
        end
      end
      StRound: begin
        if (cyc_cnt_q == CycLast) begin
          key_d     = sh_key_from_round;
          // The last round skips MixColumns, so take the post-ShiftRows tap.
          state_d   = last_round ? sh_state_SR_from_round : sh_state_from_round;
          cyc_cnt_d = '0;
          rnd_cnt_d = rnd_cnt_q + 4'd1;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CycW'(1);
        end
      end
      StFinal: begin
        // Cleaned pass: post-AK equals state XOR key10, i.e. the ciphertext.
        ct_d = sh_state_AK_from_round;
      end
      StDone: begin
`ifdef MSKAES_REG_CLEAR_EN
        if (out_ready) begin
          state_d = '0;
          key_d   = '0;
          ct_d    = '0;
        end
`endif
      end
      default: ;
    endcase
  end

  always_comb begin
    case (rnd_cnt_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready    = (fsm_q == StIdle) && !rst;
    out_valid   = (fsm_q == StDone);
    cleaning_on = (fsm_q != StRound);
    sh_RCON     = '0;
    if (fsm_q == StRound) begin
      // Share 0 carries the constant; the remaining shares stay zero.
      for (int unsigned i = 0; i < 8; i++) begin
        sh_RCON[i*d] = rcon[i];
      end
    end
  end

  assign sh_ciphertext     = ct_q;
  assign sh_state_to_round = state_q;
  assign sh_key_to_round   = key_q;

endmodule

// File: tb/tb_mskaes_128bits_round_ctrl.sv
module tb_mskaes_128bits_round_ctrl;

  localparam int D   = 2;
  localparam int LAT = 4;
  localparam int W   = 128 * D;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, cleaning_on;
  logic [W-1:0] sh_plaintext, sh_key, sh_ciphertext;
  logic [W-1:0] sh_state_to_round, sh_key_to_round;
  logic [W-1:0] sh_state_from_round, sh_key_from_round;
  logic [W-1:0] sh_state_SR_from_round, sh_state_AK_from_round;
  logic [8*D-1:0] sh_RCON;

  logic [127:0] mask_ak, mask_sr, mask_mc, mask_k;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mskaes_128bits_round_ctrl #(.d(D), .LATENCY(LAT)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .in_valid               (in_valid),
    .in_ready               (in_ready),
    .sh_plaintext           (sh_plaintext),
    .sh_key                 (sh_key),
    .out_valid              (out_valid),
    .out_ready              (out_ready),
    .sh_ciphertext          (sh_ciphertext),
    .sh_state_to_round      (sh_state_to_round),
    .sh_key_to_round        (sh_key_to_round),
    .sh_RCON                (sh_RCON),
    .cleaning_on            (cleaning_on),
    .sh_state_from_round    (sh_state_from_round),
    .sh_key_from_round      (sh_key_from_round),
    .sh_state_SR_from_round (sh_state_SR_from_round),
    .sh_state_AK_from_round (sh_state_AK_from_round)
  );

  // ---------------- sharing helpers ----------------
  function automatic logic [W-1:0] share(input logic [127:0] v, input logic [127:0] m);
    logic [W-1:0] o;
    o = '0;
    for (int i = 0; i < 128; i++) begin
      o[i*D]       = v[i] ^ m[i];
      o[i*D+D-1]   = m[i];
    end
    return o;
  endfunction

  function automatic logic [127:0] unshare(input logic [W-1:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 128; i++)
      for (int j = 0; j < D; j++) o[i] = o[i] ^ s[i*D+j];
    return o;
  endfunction

  function automatic logic [7:0] unshare8(input logic [8*D-1:0] s);
    logic [7:0] o;
    o = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < D; j++) o[i] = o[i] ^ s[i*D+j];
    return o;
  endfunction

  function automatic logic [7:0] rcon_s0(input logic [8*D-1:0] s);
    logic [7:0] o;
    for (int i = 0; i < 8; i++) o[i] = s[i*D];
    return o;
  endfunction

  function automatic logic rcon_rest(input logic [8*D-1:0] s);
    logic o;
    o = 1'b0;
    for (int i = 0; i < 8; i++)
      for (int j = 1; j < D; j++) o = o | s[i*D+j];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [7:0] exp_rcon(input int r);
    case (r)
      1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;
      5: return 8'h10;  6: return 8'h20;  7: return 8'h40;  8: return 8'h80;
      9: return 8'h1b; 10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- unmasked AES round model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, p;
    r = 8'h01;
    p = x;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] v);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(c*4+r) -: 8] = sbox(v[127-8*(((c+r)%4)*4+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] v);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = v[127-32*c -: 8];
      a1 = v[119-32*c -: 8];
      a2 = v[111-32*c -: 8];
      a3 = v[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {k[23:0], k[31:24]};
    t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Round stand-in: inputs are held stable for the whole round, so a combinational
  // model sampled at the last round cycle behaves like the pipelined datapath.
  logic [127:0] r_s, r_k, r_ak, r_sr;
  assign r_s  = unshare(sh_state_to_round);
  assign r_k  = unshare(sh_key_to_round);
  assign r_ak = r_s ^ r_k;
  assign r_sr = sub_shift(r_ak);
  assign sh_state_AK_from_round = share(r_ak, mask_ak);
  assign sh_state_SR_from_round = share(r_sr, mask_sr);
  assign sh_state_from_round    = share(mix(r_sr), mask_mc);
  assign sh_key_from_round      = share(key_next(r_k, unshare8(sh_RCON)), mask_k);

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers pt/key and returns at the sample point just after the accepting edge.
  task automatic accept(input logic [127:0] pt, input logic [127:0] key, output int ok);
    int n;
    sh_plaintext = share(pt, rand128());
    sh_key       = share(key, rand128());
    in_valid     = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    ok = int'(in_ready);
    tick();
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sh_plaintext = '0;
    sh_key = '0;
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready_high: got %b want 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || cleaning_on !== 1'b1 || sh_RCON !== '0) begin
      errors++;
      $display("FAIL reset_ctrl: got out_valid=%b cleaning_on=%b rcon=%h want 0 1 0",
               out_valid, cleaning_on, sh_RCON);
    end
    checks++;
    if (sh_ciphertext !== '0 || sh_state_to_round !== '0 || sh_key_to_round !== '0) begin
      errors++;
      $display("FAIL reset_regs: got ct=%h st=%h key=%h want all 0",
               sh_ciphertext, sh_state_to_round, sh_key_to_round);
    end
  endtask

  task automatic test_c1();
    int ok, n;
    out_ready = 1'b1;
    accept(C1_PT, C1_KEY, ok);
    in_valid = 1'b0;
    sh_plaintext = share(B_PT, rand128());
    sh_key = share(B_KEY, rand128());
    checks++;
    if (ok != 1) begin
      errors++;
      $display("FAIL c1_accept: got in_ready=0 want 1");
    end
    wait_valid(n);
    checks++;
    if (n != 10 * LAT + 1) begin
      errors++;
      $display("FAIL c1_latency: got %0d want %0d", n, 10 * LAT + 1);
    end
    checks++;
    if (unshare(sh_ciphertext) !== C1_CT) begin
      errors++;
      $display("FAIL c1_ct: got %h want %h", unshare(sh_ciphertext), C1_CT);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL c1_handshake: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
`ifdef MSKAES_REG_CLEAR_EN
    checks++;
    if (sh_state_to_round !== '0 || sh_key_to_round !== '0 || sh_ciphertext !== '0) begin
      errors++;
      $display("FAIL c1_clear: got st=%h key=%h ct=%h want all 0",
               sh_state_to_round, sh_key_to_round, sh_ciphertext);
    end
`else
    checks++;
    if (unshare(sh_ciphertext) !== C1_CT ||
        (unshare(sh_state_to_round) ^ unshare(sh_key_to_round)) !== C1_CT) begin
      errors++;
      $display("FAIL c1_retain: got ct=%h st^key=%h want %h", unshare(sh_ciphertext),
               unshare(sh_state_to_round) ^ unshare(sh_key_to_round), C1_CT);
    end
`endif
  endtask

  task automatic test_rcon_cleaning();
    int ok;
    logic [7:0] exp;
    out_ready = 1'b1;
    accept(C1_PT, C1_KEY, ok);
    in_valid = 1'b0;
    checks++;
    if (ok != 1) begin
      errors++;
      $display("FAIL rcon_accept: got in_ready=0 want 1");
    end
    for (int n = 0; n <= 10 * LAT; n++) begin
      exp = (n < 10 * LAT) ? exp_rcon(n / LAT + 1) : 8'h00;
      checks++;
      if (rcon_s0(sh_RCON) !== exp || rcon_rest(sh_RCON) !== 1'b0) begin
        errors++;
        $display("FAIL rcon_cycle%0d: got %h want share0=%h others 0", n, sh_RCON, exp);
      end
      checks++;
      if (cleaning_on !== (n >= 10 * LAT) || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL cleaning_cycle%0d: got cleaning=%b in_ready=%b want %b 0",
                 n, cleaning_on, in_ready, n >= 10 * LAT);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || cleaning_on !== 1'b1 || sh_RCON !== '0) begin
      errors++;
      $display("FAIL rcon_done: got out_valid=%b cleaning=%b rcon=%h want 1 1 0",
               out_valid, cleaning_on, sh_RCON);
    end
    checks++;
    if (unshare(sh_ciphertext) !== C1_CT) begin
      errors++;
      $display("FAIL rcon_ct: got %h want %h", unshare(sh_ciphertext), C1_CT);
    end
    tick();
  endtask

  task automatic test_b_stall();
    int ok, n;
    logic [W-1:0] ct_cap;
    out_ready = 1'b0;
    accept(B_PT, B_KEY, ok);
    // in_valid stays high with different data: it must be ignored.
    sh_plaintext = share(C1_PT, rand128());
    sh_key = share(C1_KEY, rand128());
    checks++;
    if (ok != 1) begin
      errors++;
      $display("FAIL b_accept: got in_ready=0 want 1");
    end
    wait_valid(n);
    checks++;
    if (n != 10 * LAT + 1) begin
      errors++;
      $display("FAIL b_latency: got %0d want %0d", n, 10 * LAT + 1);
    end
    checks++;
    if (unshare(sh_ciphertext) !== B_CT) begin
      errors++;
      $display("FAIL b_ct: got %h want %h", unshare(sh_ciphertext), B_CT);
    end
    ct_cap = sh_ciphertext;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sh_ciphertext !== ct_cap) begin
        errors++;
        $display("FAIL b_stall%0d: got out_valid=%b in_ready=%b ct=%h want 1 0 %h",
                 i, out_valid, in_ready, sh_ciphertext, ct_cap);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b_release: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int ok, n, seen;
    out_ready = 1'b1;
    accept(C1_PT, C1_KEY, ok);
    in_valid = 1'b0;
    for (int i = 0; i < 4 * LAT; i++) tick();
    checks++;
    if (cleaning_on !== 1'b0 || rcon_s0(sh_RCON) !== 8'h10) begin
      errors++;
      $display("FAIL mid_round5: got cleaning=%b rcon=%h want 0 share0=10", cleaning_on, sh_RCON);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst1: got in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_after1: got in_ready=%b want 1", in_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || cleaning_on !== 1'b1 ||
        sh_state_to_round !== '0) begin
      errors++;
      $display("FAIL mid_after2: got in_ready=%b out_valid=%b cleaning=%b st=%h want 1 0 1 0",
               in_ready, out_valid, cleaning_on, sh_state_to_round);
    end
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_no_output: got %0d out_valid cycles want 0", seen);
    end
    accept(C1_PT, C1_KEY, ok);
    in_valid = 1'b0;
    wait_valid(n);
    checks++;
    if (n != 10 * LAT + 1 || unshare(sh_ciphertext) !== C1_CT) begin
      errors++;
      $display("FAIL mid_rerun: got lat=%0d ct=%h want %0d %h",
               n, unshare(sh_ciphertext), 10 * LAT + 1, C1_CT);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int ok, n;
    out_ready = 1'b1;
    accept(C1_PT, C1_KEY, ok);
    // in_valid stays high; the next offer is FIPS-197 B.
    sh_plaintext = share(B_PT, rand128());
    sh_key = share(B_KEY, rand128());
    wait_valid(n);
    checks++;
    if (n != 10 * LAT + 1 || unshare(sh_ciphertext) !== C1_CT) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d ct=%h want %0d %h",
               n, unshare(sh_ciphertext), 10 * LAT + 1, C1_CT);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_handshake: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_accept: got in_ready=%b want 0", in_ready);
    end
    in_valid = 1'b0;
    wait_valid(n);
    checks++;
    if (n != 10 * LAT + 1 || unshare(sh_ciphertext) !== B_CT) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d ct=%h want %0d %h",
               n, unshare(sh_ciphertext), 10 * LAT + 1, B_CT);
    end
    tick();
  endtask

  initial begin
    mask_ak = rand128();
    mask_sr = rand128();
    mask_mc = rand128();
    mask_k  = rand128();
    test_reset();
    test_c1();
    test_rcon_cleaning();
    test_b_stall();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
